// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Default geometry, the hardwired zero register and port-slice math.
package rf_pkg;

   localparam int DW_DEF   = 32;
   localparam int AW_DEF   = 5;
   localparam int ZERO_REG = 0;

   // Low bit of lane idx inside a packed vector of w-bit lanes.
   function automatic int lsb(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register.
// Producer issue sets, any write clears, set wins when both hit.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sb_set,
   input  logic [AW-1:0]     sb_addr,
   input  logic [1:0]        wr_en,
   input  logic [2*AW-1:0]   wr_addr,
   output logic [2**AW-1:0]  pending
);

   localparam int NR = 2**AW;

   logic [NR-1:0] pend_nxt;

   // Clear on write first, then set, so a new producer stays outstanding.
   always_comb begin
      pend_nxt = pending;
      for (int j = 0; j < 2; j++) begin
         if (wr_en[j]) begin
            pend_nxt[wr_addr[lsb(j, AW) +: AW]] = 1'b0;
         end
      end
      if (sb_set) begin
         pend_nxt[sb_addr] = 1'b1;
      end
      pend_nxt[ZERO_REG] = 1'b0;
   end

   // Pending bits clear asynchronously on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= pend_nxt;
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: N read ports, two prioritised write ports,
// optional write bypass, zero register, scoreboard and debug read.
module register_file_mp
   import rf_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int AW     = AW_DEF,
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD*DW-1:0] rd_data,
   output logic [NUM_RD-1:0]    rd_pending,
   input  logic [1:0]           wr_en,
   input  logic [2*AW-1:0]      wr_addr,
   input  logic [2*DW-1:0]      wr_data,
   input  logic                 sb_set,
   input  logic [AW-1:0]        sb_addr,
   input  logic [AW-1:0]        debug_input,
   output logic [DW-1:0]        debug_output
);

   localparam int NR = 2**AW;
   localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

   logic [DW-1:0] mem [NR];
   logic [AW-1:0] wa [2];
   logic [DW-1:0] wd [2];
   logic [1:0]    wr_live;
   logic [NR-1:0] pending;

   assign wa[0] = wr_addr[lsb(0, AW) +: AW];
   assign wa[1] = wr_addr[lsb(1, AW) +: AW];
   assign wd[0] = wr_data[lsb(0, DW) +: DW];
   assign wd[1] = wr_data[lsb(1, DW) +: DW];

   // A write during reset is discarded, so it must not be forwarded either.
   assign wr_live = rst ? 2'b00 : wr_en;

   // Array update; port 1 is applied last so it wins a same-address clash.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NR; r++) begin
            mem[r] <= '0;
         end
      end else begin
         if (wr_en[0] && wa[0] != ZA) begin
            mem[wa[0]] <= wd[0];
         end
         if (wr_en[1] && wa[1] != ZA) begin
            mem[wa[1]] <= wd[1];
         end
      end
   end

   rf_scoreboard #(
      .AW (AW)
   ) u_sb (
      .clk     (clk),
      .rst     (rst),
      .sb_set  (sb_set),
      .sb_addr (sb_addr),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .pending (pending)
   );

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0] ra;
      logic [DW-1:0] rdat;
      logic          hit0;
      logic          hit1;

      assign ra   = rd_addr[lsb(i, AW) +: AW];
      assign hit0 = (BYPASS != 0) && wr_live[0] && (wa[0] == ra);
      assign hit1 = (BYPASS != 0) && wr_live[1] && (wa[1] == ra);

      // Zero register first, then port 1 bypass, port 0 bypass, array.
      always_comb begin
         rdat = mem[ra];
         if (ra == ZA) begin
            rdat = '0;
         end else if (hit1) begin
            rdat = wd[1];
         end else if (hit0) begin
            rdat = wd[0];
         end
      end

      assign rd_data[lsb(i, DW) +: DW] = rdat;
      assign rd_pending[i] = pending[ra] & ~(hit0 | hit1);
   end

   assign debug_output = (debug_input == ZA) ? '0 : mem[debug_input];

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: bypass and non-bypass builds side by side,
// checked every cycle against an array-based model of the register file.
module tb_register_file_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  wr_en;
   logic [4:0]  wa0, wa1, ra0, ra1, sb_addr, dbg_a;
   logic [31:0] wd0, wd1;
   logic        sb_set;

   logic [9:0]  rd_addr;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [63:0] rd_data_b, rd_data_n;
   logic [1:0]  pend_b, pend_n;
   logic [31:0] dbg_b, dbg_n;

   logic [31:0] m_reg [32];
   bit          m_pend [32];

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   assign rd_addr = {ra1, ra0};
   assign wr_addr = {wa1, wa0};
   assign wr_data = {wd1, wd0};

   register_file_mp #(
      .DW(32), .AW(5), .NUM_RD(2), .BYPASS(1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data_b),
      .rd_pending   (pend_b),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .sb_set       (sb_set),
      .sb_addr      (sb_addr),
      .debug_input  (dbg_a),
      .debug_output (dbg_b)
   );

   register_file_mp #(
      .DW(32), .AW(5), .NUM_RD(2), .BYPASS(0)
   ) dut_nb (
      .clk          (clk),
      .rst          (rst),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data_n),
      .rd_pending   (pend_n),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .sb_set       (sb_set),
      .sb_addr      (sb_addr),
      .debug_input  (dbg_a),
      .debug_output (dbg_n)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
      if (rst || a == 5'd0) return '0;
      if (byp && wr_en[1] && wa1 == a) return wd1;
      if (byp && wr_en[0] && wa0 == a) return wd0;
      return m_reg[a];
   endfunction

   function automatic logic [31:0] exp_pend(input logic [4:0] a, input bit byp);
      if (rst || a == 5'd0) return '0;
      if (byp && ((wr_en[0] && wa0 == a) || (wr_en[1] && wa1 == a))) return '0;
      return 32'(m_pend[a]);
   endfunction

   function automatic logic [31:0] exp_dbg(input logic [4:0] a);
      if (rst || a == 5'd0) return '0;
      return m_reg[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) begin
         m_reg[i]  = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   // Advance one clock: apply the held inputs to the model at the edge.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         clear_model();
      end else begin
         if (wr_en[0] && wa0 != 0) m_reg[wa0] = wd0;
         if (wr_en[1] && wa1 != 0) m_reg[wa1] = wd1;
         if (wr_en[0]) m_pend[wa0] = 1'b0;
         if (wr_en[1]) m_pend[wa1] = 1'b0;
         if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      wr_en  = 2'b00;
      sb_set = 1'b0;
   endtask

   function automatic logic [4:0] raddr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 3));
      return 5'($urandom);
   endfunction

   // Every falling edge: all outputs of both builds against the model.
   always @(negedge clk) begin
      chk("rd0_byp",  rd_data_b[31:0],  exp_rd(ra0, 1'b1));
      chk("rd1_byp",  rd_data_b[63:32], exp_rd(ra1, 1'b1));
      chk("rd0_nob",  rd_data_n[31:0],  exp_rd(ra0, 1'b0));
      chk("rd1_nob",  rd_data_n[63:32], exp_rd(ra1, 1'b0));
      chk("pnd0_byp", 32'(pend_b[0]),   exp_pend(ra0, 1'b1));
      chk("pnd1_byp", 32'(pend_b[1]),   exp_pend(ra1, 1'b1));
      chk("pnd0_nob", 32'(pend_n[0]),   exp_pend(ra0, 1'b0));
      chk("pnd1_nob", 32'(pend_n[1]),   exp_pend(ra1, 1'b0));
      chk("dbg_byp",  dbg_b,            exp_dbg(dbg_a));
      chk("dbg_nob",  dbg_n,            exp_dbg(dbg_a));
   end

   initial begin
      rst = 1'b1;
      idle();
      wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
      ra0 = '0; ra1 = '0; sb_addr = '0; dbg_a = '0;
      clear_model();
      tick();
      tick();
      rst = 1'b0;

      ra0 = 5'd3;
      #1 chk("reset_rd3", rd_data_b[31:0], 32'h0);

      wr_en = 2'b01; wa0 = 5'd3; wd0 = 32'hDEADBEEF;
      tick();
      idle();
      #1 chk("wr_rd3_byp", rd_data_b[31:0], 32'hDEADBEEF);
      chk("wr_rd3_nob", rd_data_n[31:0], 32'hDEADBEEF);

      dbg_a = 5'd3;
      #1 rst = 1'b1;
      clear_model();
      #1 chk("async_rst_rd", rd_data_b[31:0], 32'h0);
      chk("async_rst_dbg", dbg_n, 32'h0);
      tick();
      rst = 1'b0;

      wr_en = 2'b01; wa0 = 5'd0; wd0 = 32'h12345678;
      sb_set = 1'b1; sb_addr = 5'd0;
      ra0 = 5'd0; dbg_a = 5'd0;
      tick();
      idle();
      #1 chk("zero_rd", rd_data_b[31:0], 32'h0);
      chk("zero_dbg", dbg_b, 32'h0);
      chk("zero_pnd", 32'(pend_b[0]), 32'h0);

      wr_en = 2'b11; wa0 = 5'd7; wa1 = 5'd7;
      wd0 = 32'h1; wd1 = 32'h2; ra0 = 5'd7;
      #1 chk("clash_byp", rd_data_b[31:0], 32'h2);
      tick();
      idle();
      dbg_a = 5'd7;
      #1 chk("clash_dbg", dbg_b, 32'h2);

      wr_en = 2'b10; wa1 = 5'd9; wd1 = 32'h1111;
      tick();
      wr_en = 2'b01; wa0 = 5'd9; wd0 = 32'hA5A5;
      ra1 = 5'd9; dbg_a = 5'd9;
      #1 chk("byp_rd1", rd_data_b[63:32], 32'hA5A5);
      chk("byp_dbg_old", dbg_b, 32'h1111);
      chk("nob_rd1_old", rd_data_n[63:32], 32'h1111);
      tick();
      idle();
      #1 chk("nob_rd1_new", rd_data_n[63:32], 32'hA5A5);

      sb_set = 1'b1; sb_addr = 5'd5;
      tick();
      idle();
      ra0 = 5'd5;
      #1 chk("sb_set_pnd", 32'(pend_b[0]), 32'h1);
      wr_en = 2'b10; wa1 = 5'd5; wd1 = 32'h55;
      #1 chk("sb_wr_byp", 32'(pend_b[0]), 32'h0);
      chk("sb_wr_nob", 32'(pend_n[0]), 32'h1);
      tick();
      idle();
      #1 chk("sb_clr_byp", 32'(pend_b[0]), 32'h0);
      chk("sb_clr_nob", 32'(pend_n[0]), 32'h0);

      sb_set = 1'b1; sb_addr = 5'd5;
      wr_en = 2'b01; wa0 = 5'd5; wd0 = 32'h66;
      tick();
      idle();
      #1 chk("sb_setwins_byp", 32'(pend_b[0]), 32'h1);
      chk("sb_setwins_nob", 32'(pend_n[0]), 32'h1);

      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0;
         if (rst) clear_model();
         wr_en   = 2'($urandom);
         wa0     = raddr();
         wa1     = raddr();
         wd0     = $urandom;
         wd1     = $urandom;
         sb_set  = 1'($urandom);
         sb_addr = raddr();
         ra0     = raddr();
         ra1     = raddr();
         dbg_a   = raddr();
         tick();
      end
      rst = 1'b0;

      for (int n = 0; n < 40; n++) begin
         wr_en   = 2'($urandom);
         wa0     = 5'($urandom);
         wa1     = 5'($urandom);
         wd0     = $urandom;
         wd1     = $urandom;
         sb_set  = 1'($urandom);
         sb_addr = 5'($urandom);
         tick();
      end
      idle();

      for (int a = 0; a < 32; a++) begin
         ra0   = 5'(a);
         ra1   = 5'(31 - a);
         dbg_a = 5'(a);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
